// File: rtl/serial_add_sequencer_if.sv
// Parallel operand/result handshake between a requester and serial_add_sequencer.
// The SERIAL_SUB_EN macro adds the 'sub' request bit (subtract when set).
`timescale 1ns/1ps
interface serial_add_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy, done, sum
    );

    // Sequencer side.
    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy, done, sum
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Operand/result sequencer around a 2-state Mealy serial adder.
// Operands are shifted out LSB-first on x_o/y_o; the adder's sum bit s_i is
// collected back into a (WIDTH+1)-bit result with carry-out as MSB.
// Optional feature macro: SERIAL_SUB_EN (adds 'sub' and a carry-preset cycle
// so the same adder computes a + ~b + 1).
`timescale 1ns/1ps
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,   // asynchronous, active-low
    serial_add_sequencer_if.slave bus,
    input  logic                 s_i,     // serial sum bit from the adder
    output logic                 x_o,     // serial A bit to the adder
    output logic                 y_o      // serial B bit to the adder
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_SUB_EN
    typedef enum logic [2:0] {IDLE, SHIFT, CARRY, DONE, PRESET} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, CARRY, DONE} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;    // res_q[k] = sum bit captured in SHIFT cycle k
    logic [WIDTH:0]   sum_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_SUB_EN
    logic             sub_q;
`endif

    // Sequencer FSM: operand capture, bit shifting, result collection, handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q <= bus.a;
                        b_sh_q <= bus.b;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef SERIAL_SUB_EN
                        sub_q   <= bus.sub;
                        state_q <= bus.sub ? PRESET : SHIFT;
`else
                        state_q <= SHIFT;
`endif
                    end
                end
`ifdef SERIAL_SUB_EN
                // x=y=1 this cycle pushes the adder into its carry state.
                PRESET: state_q <= SHIFT;
`endif
                SHIFT: begin
                    res_q  <= {s_i, res_q[WIDTH-1:1]};
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= CARRY;
                    end
                end
                CARRY: begin
                    // With x=y=0 the adder emits its carry and drops back to no-carry.
                    sum_q   <= {s_i, res_q};
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Adder inputs depend only on state and shift-register LSBs (no path from start or s_i).
    always_comb begin
        x_o = 1'b0;
        y_o = 1'b0;
        case (state_q)
            SHIFT: begin
                x_o = a_sh_q[0];
`ifdef SERIAL_SUB_EN
                y_o = b_sh_q[0] ^ sub_q;
`else
                y_o = b_sh_q[0];
`endif
            end
`ifdef SERIAL_SUB_EN
            PRESET: begin
                x_o = 1'b1;
                y_o = 1'b1;
            end
`endif
            default: begin
                x_o = 1'b0;
                y_o = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Testbench: sequencer plus a behavioural serial adder on a shared reset.
// Driver pushes expected results into a queue; a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_serial_add_sequencer;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic s, x, y;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .s_i   (s),
        .x_o   (x),
        .y_o   (y)
    );

    // Behavioural 2-state Mealy serial adder (S0 = no carry, S1 = carry).
    logic carry_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) carry_q <= 1'b0;
        else        carry_q <= (x & y) | (x & carry_q) | (y & carry_q);
    end
    assign s = x ^ y ^ carry_q;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned a;
        int unsigned b;
        bit          sub;
        logic [W:0]  sum;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain unsigned arithmetic modulo 2^(W+1).
    function automatic logic [W:0] ref_result(input int unsigned a, input int unsigned b, input bit sub);
        int unsigned mask = (1 << W) - 1;
        int unsigned r;
        if (sub) r = a + ((~b) & mask) + 1;
        else     r = a + b;
        return (W+1)'(r % (1 << (W + 1)));
    endfunction

    // Monitor: pop and compare on every done pulse; sum must hold otherwise.
    logic [W:0] prev_sum = '0;
    logic       prev_done = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_sum  = bus.sum;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn a=%0d b=%0d sub=%0d sum=%b expected=%b cycle=%0d", e.a, e.b, e.sub, bus.sum, e.sum, cyc);
                    chk("sum", 64'(bus.sum), 64'(e.sum));
                    chk("done_latency", 64'(cyc), 64'(e.due));
                end
                chk("done_one_cycle", 64'(prev_done), 64'd0);
            end else begin
                chk("sum_hold", 64'(bus.sum), 64'(prev_sum));
            end
            prev_sum  = bus.sum;
            prev_done = bus.done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (bus.busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // mode 0: plain; 1: spurious start in SHIFT; 2: spurious start in DONE; 3: reset in 2nd SHIFT cycle
    task automatic run_op(input int unsigned a, input int unsigned b, input bit sub, input int mode);
        exp_t e;
        int   c0;
        int   n;
        wait_idle();
        bus.a = W'(a);
        bus.b = W'(b);
`ifdef SERIAL_SUB_EN
        bus.sub = sub;
`endif
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        c0 = cyc;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        e.a = a; e.b = b; e.sub = sub;
        e.sum = ref_result(a, b, sub);
        e.due = c0 + W + 1 + (sub ? 1 : 0);
        exp_q.push_back(e);
        if (mode == 1) begin
            @(negedge clock);
            @(negedge clock);
            bus.a = W'(a + 3); bus.b = W'(b + 5);
            bus.start = 1'b1;
            @(posedge clock);
            #1 bus.start = 1'b0;
        end else if (mode == 2) begin
            n = 0;
            @(negedge clock);
            while (!bus.done && n < 40) begin
                @(negedge clock);
                n++;
            end
            if (!bus.done) chk("done_timeout", 64'd1, 64'd0);
            bus.a = W'(a ^ 6); bus.b = W'(b ^ 9);
            bus.start = 1'b1;
            @(posedge clock);
            #1 bus.start = 1'b0;
            @(negedge clock);
            chk("busy_low_after_done", 64'(bus.busy), 64'd0);
        end else if (mode == 3) begin
            @(negedge clock);
            @(negedge clock);
            reset = 1'b0;
            #1;
            exp_q.delete();
            chk("rst_x", 64'(x), 64'd0);
            chk("rst_y", 64'(y), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_sum", 64'(bus.sum), 64'd0);
            @(negedge clock);
            #2 reset = 1'b1;
        end
    endtask

    initial begin
        int budget;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_SUB_EN
        bus.sub = 1'b0;
`endif
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_sum", 64'(bus.sum), 64'd0);
        chk("reset_xy", 64'({x, y}), 64'd0);
        #11 reset = 1'b1;

        run_op(5, 3, 1'b0, 0);
        run_op(15, 15, 1'b0, 0);
        run_op(0, 0, 1'b0, 0);
        run_op(9, 9, 1'b0, 0);
        run_op(5, 3, 1'b0, 1);
        run_op(6, 7, 1'b0, 2);
        run_op(7, 9, 1'b0, 3);
        run_op(2, 1, 1'b0, 0);
`ifdef SERIAL_SUB_EN
        run_op(5, 3, 1'b1, 0);
        run_op(3, 5, 1'b1, 0);
        run_op(0, 15, 1'b1, 2);
`endif
        for (int i = 0; i < 24; i++) begin
            bit sb = 1'b0;
`ifdef SERIAL_SUB_EN
            sb = 1'($urandom_range(0, 1));
`endif
            run_op($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), sb,
                   int'($urandom_range(0, 2)));
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
